// File: rtl/multicycle_control.sv
// Moore FSM sequencing a shared-memory multi-cycle RISC-V datapath (R-format, ld, sd, beq).
// Define PERF_CNT_EN to add the instr_cnt / cycle_cnt performance counter outputs.
module multicycle_control #(
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                pc_source,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                illegal,
    output logic [3:0]          state
`ifdef PERF_CNT_EN
   ,output logic [CNT_W-1:0]    instr_cnt,
    output logic [CNT_W-1:0]    cycle_cnt
`endif
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        R_EXEC   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_LD  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_SD  = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(51);
    localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(99);

    state_e     state_q, state_d;
    logic       pc_write_cond_q, pc_write_cond_d;
    logic       pc_source_q, pc_source_d;
    logic       i_or_d_q, i_or_d_d;
    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       reg_write_q, reg_write_d;
    logic       alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       illegal_q, illegal_d;

    // The branch decision is taken in the datapath; zero never steers the sequencer.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LD, OP_SD: state_d = MEM_ADDR;
                    OP_R:         state_d = R_EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    default:      state_d = TRAP;
                endcase
            end
            MEM_ADDR: state_d = (opcode == OP_LD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_d = MEM_WB;
            MEM_WB:   state_d = FETCH;
            MEM_WR:   if (mem_ready) state_d = FETCH;
            R_EXEC:   state_d = R_WB;
            R_WB:     state_d = FETCH;
            BRANCH:   state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        pc_write_cond_d = 1'b0;
        pc_source_d     = 1'b0;
        i_or_d_d        = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        reg_write_d     = 1'b0;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = 2'b00;
        alu_op_d        = 2'b00;
        illegal_d       = illegal_q | (state_d == TRAP);
        case (state_d)
            FETCH: begin
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;
            end
            DECODE:   alu_src_b_d = 2'b10;
            MEM_ADDR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            MEM_RD: begin
                mem_read_d = 1'b1;
                i_or_d_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            MEM_WR: begin
                mem_write_d = 1'b1;
                i_or_d_d    = 1'b1;
            end
            R_EXEC: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            R_WB:     reg_write_d = 1'b1;
            BRANCH: begin
                alu_src_a_d     = 1'b1;
                alu_op_d        = 2'b01;
                pc_write_cond_d = 1'b1;
                pc_source_d     = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             instr_done;

    always_comb begin
        instr_done  = (state_d == FETCH) &&
                      ((state_q == MEM_WB) || (state_q == MEM_WR) ||
                       (state_q == R_WB)   || (state_q == BRANCH));
        instr_cnt_d = instr_done ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
        cycle_cnt_d = ((state_q != IDLE) && (state_q != TRAP)) ? cycle_cnt_q + CNT_W'(1)
                                                               : cycle_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pc_write_cond_q <= 1'b0;
            pc_source_q     <= 1'b0;
            i_or_d_q        <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_write_q     <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            alu_op_q        <= 2'b00;
            illegal_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_write_cond_q <= pc_write_cond_d;
            pc_source_q     <= pc_source_d;
            i_or_d_q        <= i_or_d_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            reg_write_q     <= reg_write_d;
            alu_src_a_q     <= alu_src_a_d;
            alu_src_b_q     <= alu_src_b_d;
            alu_op_q        <= alu_op_d;
            illegal_q       <= illegal_d;
        end
    end

    // IR/PC load must follow mem_ready in the same cycle, so these two stay combinational.
    assign ir_write      = (state_q == FETCH) && mem_ready;
    assign pc_write      = (state_q == FETCH) && mem_ready;
    assign pc_write_cond = pc_write_cond_q;
    assign pc_source     = pc_source_q;
    assign i_or_d        = i_or_d_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_to_reg    = mem_to_reg_q;
    assign reg_write     = reg_write_q;
    assign alu_src_a     = alu_src_a_q;
    assign alu_src_b     = alu_src_b_q;
    assign alu_op        = alu_op_q;
    assign illegal       = illegal_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction state traces built from the instruction
// step lists, random memory wait states, latency and per-cycle control word checks.
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3, ST_MEM_RD = 4;
    localparam int ST_MEM_WB = 5, ST_MEM_WR = 6, ST_R_EXEC = 7, ST_R_WB = 8, ST_BRANCH = 9;
    localparam int ST_TRAP = 10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd51;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, pc_source, ir_write, i_or_d;
    logic       mem_read, mem_write, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;
`ifdef PERF_CNT_EN
    logic [CW-1:0] instr_cnt, cycle_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned m_instr = 0;
    int unsigned m_cycles = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .OPCODE_W(7),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .opcode(opcode),
        .zero(zero),
        .mem_ready(mem_ready),
        .pc_write(pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_source(pc_source),
        .ir_write(ir_write),
        .i_or_d(i_or_d),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_to_reg(mem_to_reg),
        .reg_write(reg_write),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_op(alu_op),
        .illegal(illegal),
        .state(state)
`ifdef PERF_CNT_EN
       ,.instr_cnt(instr_cnt),
        .cycle_cnt(cycle_cnt)
`endif
    );

    // Control word each state must present, straight from the per-state output table.
    function automatic ctrl_t exp_ctrl(input int st, input logic rdy);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            ST_DECODE:   c.alu_src_b = 2'b10;
            ST_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            ST_MEM_RD:   begin c.mem_read = 1; c.i_or_d = 1; end
            ST_MEM_WB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
            ST_MEM_WR:   begin c.mem_write = 1; c.i_or_d = 1; end
            ST_R_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            ST_R_WB:     c.reg_write = 1;
            ST_BRANCH:   begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 1; end
            ST_TRAP:     c.illegal = 1;
            default:     ;
        endcase
        return c;
    endfunction

    task automatic check_cycle(input int st, input string tag);
        ctrl_t obs, exp;
        logic [3:0] exp_st;
        logic inv;
        obs = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal};
        exp = exp_ctrl(st, mem_ready);
        exp_st = st[3:0];
        n_vec++;
        assert (state === exp_st) else begin
            n_err++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp_st);
        end
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s ctrl(st=%0d) observed=%b expected=%b", tag, st, obs, exp);
        end
        inv = (mem_read & mem_write) | (reg_write & (mem_read | mem_write));
        n_vec++;
        assert (inv === 1'b0) else begin
            n_err++;
            $error("FAIL %s invariant observed=%b expected=0", tag, inv);
        end
`ifdef PERF_CNT_EN
        n_vec++;
        assert (instr_cnt === m_instr[CW-1:0]) else begin
            n_err++;
            $error("FAIL %s instr_cnt observed=%0d expected=%0d", tag, instr_cnt, m_instr[CW-1:0]);
        end
        n_vec++;
        assert (cycle_cnt === m_cycles[CW-1:0]) else begin
            n_err++;
            $error("FAIL %s cycle_cnt observed=%0d expected=%0d", tag, cycle_cnt, m_cycles[CW-1:0]);
        end
`endif
        if (st != ST_IDLE && st != ST_TRAP) m_cycles++;
    endtask

    // Called at a negedge; leaves the bench at the negedge where the DUT is in its first FETCH.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        m_instr = 0;
        m_cycles = 0;
        check_cycle(ST_IDLE, tag);
        @(negedge clk);
        check_cycle(ST_IDLE, tag);
        rst_n = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check_cycle(ST_IDLE, tag);
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input string tag);
        int st_q[$];
        logic rdy_q[$];
        int k, lat;
        bit left_fetch, done;
        for (int i = 0; i < fw; i++) begin st_q.push_back(ST_FETCH); rdy_q.push_back(1'b0); end
        st_q.push_back(ST_FETCH);  rdy_q.push_back(1'b1);
        st_q.push_back(ST_DECODE); rdy_q.push_back(1'($urandom_range(0, 1)));
        case (opc)
            7'd51: begin
                st_q.push_back(ST_R_EXEC); st_q.push_back(ST_R_WB);
                repeat (2) rdy_q.push_back(1'($urandom_range(0, 1)));
                lat = 4;
            end
            7'd3: begin
                st_q.push_back(ST_MEM_ADDR); rdy_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) begin st_q.push_back(ST_MEM_RD); rdy_q.push_back(1'b0); end
                st_q.push_back(ST_MEM_RD); rdy_q.push_back(1'b1);
                st_q.push_back(ST_MEM_WB); rdy_q.push_back(1'($urandom_range(0, 1)));
                lat = 5;
            end
            7'd35: begin
                st_q.push_back(ST_MEM_ADDR); rdy_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) begin st_q.push_back(ST_MEM_WR); rdy_q.push_back(1'b0); end
                st_q.push_back(ST_MEM_WR); rdy_q.push_back(1'b1);
                lat = 4;
            end
            default: begin
                st_q.push_back(ST_BRANCH); rdy_q.push_back(1'($urandom_range(0, 1)));
                lat = 3;
            end
        endcase
        if (opc == 7'd3 || opc == 7'd35) lat += mw;
        lat += fw;
        opcode = opc;
        k = 0;
        left_fetch = 0;
        done = 0;
        while (!done && k < st_q.size() + 4) begin
            mem_ready = (k < st_q.size()) ? rdy_q[k] : 1'b1;
            zero = 1'($urandom_range(0, 1));
            #1;
            if (k < st_q.size()) check_cycle(st_q[k], tag);
            if (state != 4'(ST_FETCH)) left_fetch = 1;
            @(negedge clk);
            k++;
            if (left_fetch && state == 4'(ST_FETCH)) done = 1;
        end
        m_instr++;
        n_vec++;
        assert (k === lat) else begin
            n_err++;
            $error("FAIL %s latency observed=%0d expected=%0d", tag, k, lat);
        end
    endtask

    task automatic run_trap(input logic [6:0] opc, input int fw, input string tag);
        opcode = opc;
        for (int i = 0; i <= fw; i++) begin
            mem_ready = (i == fw);
            #1;
            check_cycle(ST_FETCH, tag);
            @(negedge clk);
        end
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check_cycle(ST_DECODE, tag);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #1;
            check_cycle(ST_TRAP, tag);
            @(negedge clk);
        end
    endtask

    // ld parked in MEM_RD waiting on memory, then reset lands asynchronously.
    task automatic ld_reset_midwait();
        int st_l[5];
        logic rdy_l[5];
        st_l  = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_RD};
        rdy_l = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 7'd3;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy_l[i];
            #1;
            check_cycle(st_l[i], "ld_midwait");
            if (i < 4) @(negedge clk);
        end
        #2;
        do_reset("midwait_rst");
    endtask

    logic [6:0] legal_ops [4];
    logic [6:0] opr;

    initial begin
        legal_ops = '{7'd51, 7'd3, 7'd35, 7'd99};
        @(negedge clk);
        do_reset("por");
        run_instr(7'd51, 0, 0, "r_basic");
        run_instr(7'd3, 2, 3, "ld_wait");
        run_instr(7'd35, 0, 0, "sd");
        run_instr(7'd99, 0, 0, "beq");
        do_reset("pre_r17");
        repeat (17) run_instr(7'd51, 0, 0, "r17");
        ld_reset_midwait();
        repeat (150) begin
            if ($urandom_range(0, 19) == 0) begin
                opr = 7'($urandom_range(0, 127));
                if (opr == 7'd3 || opr == 7'd35 || opr == 7'd51 || opr == 7'd99) opr = 7'h13;
                run_trap(opr, int'($urandom_range(0, 2)), "rand_trap");
                @(negedge clk);
                #3;
                do_reset("rand_trap_rst");
            end else begin
                run_instr(legal_ops[$urandom_range(0, 3)], int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), "rand");
            end
        end
        run_trap(7'h13, 0, "trap13");
        do_reset("trap_rst");
        run_instr(7'd51, 0, 0, "after_trap");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
